// File: rtl/cvp14_mem_responder.sv
// CVP14 word-addressed memory responder: fixed-latency pipelined reads, zero-fill INIT, sticky Err.
// Optional RdCount/WrCount/ErrCount statistics ports are enabled by defining CVP14_MEM_STATS_EN.
module cvp14_mem_responder #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned READ_LAT       = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk1,
    input  logic        Reset_n,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        RdValid,
    output logic        Ready,
    output logic        Err
`ifdef CVP14_MEM_STATS_EN
    ,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount,
    output logic [7:0]  ErrCount
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [0:0] {StInit, StServe} stateT;

    stateT             stateQ, stateD;
    logic [15:0]       mem [Depth];
    logic [ADDR_W-1:0] initCnt;
    logic              initActive;
    logic              inRange;
    logic              rdAccept;
    logic              wrCommit;
    logic              errEvent;
    logic [15:0]       rdWord;
    logic [READ_LAT-1:0] pipeValid;
    logic [15:0]       pipeData [READ_LAT];

    always_ff @(posedge Clk1) begin
        if (!Reset_n) begin
            stateQ <= CLEAR_ON_RESET ? StInit : StServe;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StInit:  if (&initCnt) stateD = StServe;
            StServe: stateD = StServe;
            default: stateD = StInit;
        endcase
    end

    always_comb begin
        initActive = (stateQ == StInit);
    end

    // Bus requests only count once Ready is up; Ready implies SERVE.
    always_comb begin
        inRange  = ((32'(Addr) >> ADDR_W) == 32'd0);
        rdAccept = Ready & RD & ~WR;
        wrCommit = Ready & WR & inRange;
        errEvent = (RD | WR) & (~Ready | (RD & WR) | ~inRange);
        rdWord   = inRange ? mem[Addr[ADDR_W-1:0]] : 16'h0000;
    end

    always_ff @(posedge Clk1) begin
        if (Reset_n) begin
            if (initActive) begin
                mem[initCnt] <= 16'h0000;
            end else if (wrCommit) begin
                mem[Addr[ADDR_W-1:0]] <= DataIn;
            end
        end
    end

    always_ff @(posedge Clk1) begin
        if (!Reset_n) begin
            initCnt <= '0;
            Ready   <= 1'b0;
            Err     <= 1'b0;
        end else begin
            if (initActive) initCnt <= initCnt + ADDR_W'(1);
            Ready <= (stateD == StServe);
            if (errEvent) Err <= 1'b1;
        end
    end

    // Read data is captured at request time, then delayed so the response lands READ_LAT
    // edges after the request edge.
    always_ff @(posedge Clk1) begin
        if (!Reset_n) begin
            pipeValid <= '0;
            for (int i = 0; i < READ_LAT; i++) pipeData[i] <= 16'h0000;
            RdValid <= 1'b0;
            DataOut <= 16'h0000;
        end else begin
            pipeValid[0] <= rdAccept;
            pipeData[0]  <= rdWord;
            for (int i = 1; i < READ_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeData[i]  <= pipeData[i-1];
            end
            RdValid <= pipeValid[READ_LAT-1];
            if (pipeValid[READ_LAT-1]) DataOut <= pipeData[READ_LAT-1];
        end
    end

`ifdef CVP14_MEM_STATS_EN
    always_ff @(posedge Clk1) begin
        if (!Reset_n) begin
            RdCount  <= '0;
            WrCount  <= '0;
            ErrCount <= '0;
        end else if (stateQ == StServe) begin
            if (rdAccept && !(&RdCount)) RdCount <= RdCount + 16'd1;
            if (wrCommit && !(&WrCount)) WrCount <= WrCount + 16'd1;
            if (errEvent && !(&ErrCount)) ErrCount <= ErrCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Self-checking bench for cvp14_mem_responder (ADDR_W=5, READ_LAT=3): directed table,
// corner-case sequences and randomized traffic against a transaction-level reference model.
module tb_cvp14_mem_responder;

    localparam int AW    = 5;
    localparam int LAT   = 3;
    localparam int DEPTH = 32;

    logic        Clk1 = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] Addr = 16'h0;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [15:0] DataIn = 16'h0;
    logic [15:0] DataOut;
    logic        RdValid;
    logic        Ready;
    logic        Err;
`ifdef CVP14_MEM_STATS_EN
    logic [15:0] RdCount;
    logic [15:0] WrCount;
    logic [7:0]  ErrCount;
`endif

    always #5 Clk1 = ~Clk1;

    cvp14_mem_responder #(
        .ADDR_W        (AW),
        .READ_LAT      (LAT),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .Clk1   (Clk1),
        .Reset_n(Reset_n),
        .Addr   (Addr),
        .RD     (RD),
        .WR     (WR),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .RdValid(RdValid),
        .Ready  (Ready),
        .Err    (Err)
`ifdef CVP14_MEM_STATS_EN
        ,
        .RdCount (RdCount),
        .WrCount (WrCount),
        .ErrCount(ErrCount)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: memory contents, outstanding responses with due cycle, sticky error.
    typedef struct {
        int          due;
        logic [15:0] data;
    } respT;

    respT        respQ[$];
    logic [15:0] memM [DEPTH];
    int          cyc = 0;
    bit          readyM = 1'b0;
    int          initLeft = DEPTH;
    bit          errM = 1'b0;
    bit          expValid = 1'b0;
    logic [15:0] lastD = 16'h0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] din;
        bit          expV;
        logic [15:0] expD;
        bit          expErr;
    } vecT;

    vecT vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        respQ.delete();
        lastD    = 16'h0;
        errM     = 1'b0;
        readyM   = 1'b0;
        initLeft = DEPTH;
        expValid = 1'b0;
        for (int i = 0; i < DEPTH; i++) memM[i] = 16'h0;
    endtask

    task automatic modelStep(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [15:0] din);
        bit   inR;
        respT r;
        inR = (32'(addr) < DEPTH);
        if (!readyM) begin
            if (rd || wr) errM = 1'b1;
            initLeft--;
            if (initLeft == 0) readyM = 1'b1;
        end else if (rd && wr) begin
            errM = 1'b1;
            if (inR) memM[addr[AW-1:0]] = din;
        end else if (wr) begin
            if (inR) memM[addr[AW-1:0]] = din;
            else errM = 1'b1;
        end else if (rd) begin
            r.due  = cyc + LAT;
            r.data = inR ? memM[addr[AW-1:0]] : 16'h0000;
            respQ.push_back(r);
            if (!inR) errM = 1'b1;
        end
        expValid = 1'b0;
        if (respQ.size() > 0 && respQ[0].due == cyc) begin
            expValid = 1'b1;
            r        = respQ.pop_front();
            lastD    = r.data;
        end
        cyc++;
    endtask

    task automatic checkAll();
        check("RdValid", 32'(RdValid), 32'(expValid));
        check("DataOut", 32'(DataOut), 32'(lastD));
        check("Ready", 32'(Ready), 32'(readyM));
        check("Err", 32'(Err), 32'(errM));
    endtask

    task automatic step(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] din);
        RD     = rd;
        WR     = wr;
        Addr   = addr;
        DataIn = din;
        @(posedge Clk1);
        modelStep(rd, wr, addr, din);
        #1;
        checkAll();
        RD = 1'b0;
        WR = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Bus requests held active during reset must have no effect.
    task automatic resetCycles(input int n);
        Reset_n = 1'b0;
        RD      = 1'b1;
        WR      = 1'b1;
        Addr    = 16'h0003;
        DataIn  = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk1);
            modelReset();
            cyc++;
            #1;
            checkAll();
        end
        Reset_n = 1'b1;
        RD      = 1'b0;
        WR      = 1'b0;
    endtask

    task automatic waitReady(input string name, output int cnt);
        cnt = 0;
        while (!Ready && cnt < 200) begin
            idle(1);
            cnt++;
        end
        if (!Ready) check(name, 32'(Ready), 32'd1);
    endtask

    initial begin
        int cnt;

        vecs[0]  = '{1, 0, 16'h03, 16'hBEEF, 0, 16'h0000, 0}; // write then read-back
        vecs[1]  = '{0, 0, 16'h03, 16'h0000, 0, 16'h0000, 0};
        vecs[2]  = '{0, 0, 16'h00, 16'h0000, 0, 16'h0000, 0};
        vecs[3]  = '{0, 0, 16'h00, 16'h0000, 0, 16'h0000, 0};
        vecs[4]  = '{0, 0, 16'h00, 16'h0000, 1, 16'hBEEF, 0};
        vecs[5]  = '{1, 0, 16'h05, 16'h0000, 0, 16'hBEEF, 0};
        vecs[6]  = '{0, 0, 16'h00, 16'h0000, 0, 16'hBEEF, 0};
        vecs[7]  = '{0, 0, 16'h00, 16'h0000, 0, 16'hBEEF, 0};
        vecs[8]  = '{0, 0, 16'h00, 16'h0000, 1, 16'h0000, 0};
        vecs[9]  = '{1, 0, 16'h09, 16'h0000, 0, 16'h0000, 0}; // read in flight, then write
        vecs[10] = '{0, 1, 16'h09, 16'h5555, 0, 16'h0000, 0};
        vecs[11] = '{0, 0, 16'h00, 16'h0000, 0, 16'h0000, 0};
        vecs[12] = '{0, 0, 16'h00, 16'h0000, 1, 16'h0000, 0};
        vecs[13] = '{1, 0, 16'h09, 16'h0000, 0, 16'h0000, 0};
        vecs[14] = '{0, 0, 16'h00, 16'h0000, 0, 16'h0000, 0};
        vecs[15] = '{0, 0, 16'h00, 16'h0000, 0, 16'h0000, 0};
        vecs[16] = '{0, 0, 16'h00, 16'h0000, 1, 16'h5555, 0};
        // Row 0 is a write; the read of row 1 is encoded by swapping flags below.
        vecs[0].rd = 0; vecs[0].wr = 1;
        vecs[1].rd = 1;

        // Reset state and INIT length.
        resetCycles(2);
        waitReady("readyTimeout", cnt);
        check("readyLatency", 32'(cnt), 32'(DEPTH));

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
            check("vecValid", 32'(RdValid), 32'(vecs[i].expV));
            check("vecData", 32'(DataOut), 32'(vecs[i].expD));
            check("vecErr", 32'(Err), 32'(vecs[i].expErr));
        end

        // Back-to-back 16-word burst.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(16 + i), 16'(256 + i));
        for (int j = 0; j < 16 + LAT; j++) begin
            if (j < 16) step(1'b1, 1'b0, 16'(16 + j), 16'h0);
            else idle(1);
            check("burstValid", 32'(RdValid), 32'(j >= LAT));
            if (j >= LAT) check("burstData", 32'(DataOut), 32'(256 + j - LAT));
        end

        // RD and WR together: write lands, read dropped, Err sticky.
        step(1'b1, 1'b1, 16'h0007, 16'h1234);
        idle(10);
        check("errSticky", 32'(Err), 32'd1);
        step(1'b1, 1'b0, 16'h0007, 16'h0);
        idle(LAT);
        check("conflictWrite", 32'(DataOut), 32'h1234);

        // Out-of-range accesses.
        resetCycles(1);
        waitReady("readyTimeout2", cnt);
        step(1'b0, 1'b1, 16'h0000, 16'hA5A5);
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        idle(LAT);
        check("mem0Data", 32'(DataOut), 32'hA5A5);
        step(1'b1, 1'b0, 16'h0020, 16'h0);
        idle(LAT);
        check("oorValid", 32'(RdValid), 32'd1);
        check("oorData", 32'(DataOut), 32'h0000);
        check("oorErr", 32'(Err), 32'd1);
        step(1'b0, 1'b1, 16'h0020, 16'hDEAD);
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        idle(LAT);
        check("oorWriteDropped", 32'(DataOut), 32'hA5A5);

        // Reset in the middle of a burst discards pending responses and restarts INIT.
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        step(1'b1, 1'b0, 16'h0001, 16'h0);
        resetCycles(1);
        check("resetFlushValid", 32'(RdValid), 32'd0);
        step(1'b1, 1'b0, 16'h0000, 16'h0); // ignored during INIT, flags Err
        waitReady("readyTimeout3", cnt);
        check("readyAfterMidReset", 32'(cnt + 1), 32'(DEPTH));

        // Randomized traffic, mostly legal so data checks stay meaningful.
        resetCycles(1);
        waitReady("readyTimeout4", cnt);
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [15:0] a;
            r = int'($urandom_range(0, 99));
            a = ($urandom_range(0, 199) == 0) ? 16'(32 + $urandom_range(0, 60000))
                                              : 16'($urandom_range(0, DEPTH - 1));
            if (r < 40)      step(1'b1, 1'b0, a, 16'($urandom));
            else if (r < 75) step(1'b0, 1'b1, a, 16'($urandom));
            else if (r < 76) step(1'b1, 1'b1, a, 16'($urandom));
            else             idle(1);
        end
        // Random traffic including requests during INIT.
        resetCycles(1);
        for (int n = 0; n < 120; n++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 16'($urandom_range(0, DEPTH - 1)), 16'h0);
        end
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
